fft_cbfp_stage: RTL and testbench
=================================

FFT_CBFP_STAGE -- requirements
Module: fft_cbfp_stage

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 25, meaning signed input sample width.
REQ-002 SHALL have parameter WIDTH_OUT, default 12, meaning signed output sample width, less than WIDTH_IN.
REQ-003 SHALL have parameter LANES, default 16, meaning complex samples per beat.
REQ-004 SHALL have parameter GROUP, default 8, meaning lanes sharing one exponent; LANES divisible by GROUP.
REQ-005 SHALL have parameter FRAME_LEN, default 512, meaning samples per frame; divisible by LANES.
REQ-006 SHALL have parameter ROUND_MODE, default 0, meaning 0 = truncate, 1 = round-half-up with saturation.
REQ-007 SHALL have port clk, input, 1, meaning the single clock; one clock; reset is synchronous and active-high.
REQ-008 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-009 SHALL have port in_valid, input, 1, meaning input beat valid.
REQ-010 SHALL have port in_ready, output, 1, meaning stage accepts a beat.
REQ-011 SHALL have port din_i / din_q, input, LANES x WIDTH_IN signed, meaning I/Q samples.
REQ-012 SHALL have port out_valid, output, 1, meaning output beat valid.
REQ-013 SHALL have port out_ready, input, 1, meaning downstream accepts.
REQ-014 SHALL have port dout_i / dout_q, output, LANES x WIDTH_OUT signed, meaning normalised samples.
REQ-015 SHALL have port exp_out, output, (LANES/GROUP) x EXP_W, where EXP_W = clog2(WIDTH_IN), meaning per-group shift applied.
REQ-016 SHALL have port out_last, output, 1, meaning last beat of frame.
REQ-017 SHALL have port frame_exp, output, EXP_W, meaning minimum group shift over the completed frame.
REQ-018 SHALL have port frame_exp_valid, output, 1, meaning one-cycle strobe for frame_exp.

Function
REQ-019 SHALL compute per sample the leading-sign count s = number of bits below the MSB equal to the MSB, range 0..WIDTH_IN-1; 0 and -1 both give WIDTH_IN-1.
REQ-020 SHALL set each group shift to the minimum s over all I and Q samples of the GROUP lanes (joint I/Q exponent).
REQ-021 SHALL form y = (x <<< shift) >>> (WIDTH_IN-WIDTH_OUT) at full precision, then keep WIDTH_OUT LSBs when ROUND_MODE=0.
REQ-022 SHALL, when ROUND_MODE=1, add 2^(WIDTH_IN-WIDTH_OUT-1) before the right shift and saturate to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1].
REQ-023 SHALL register the result: latency one cycle from accepted input beat to out_valid; dout, exp_out and out_last aligned.
REQ-024 SHALL use the handshake in_ready = !out_valid || out_ready; a beat transfers on valid&&ready at each side.
REQ-025 SHALL hold dout, exp_out and out_last stable while out_valid && !out_ready.
REQ-026 SHALL count accepted beats 0..FRAME_LEN/LANES-1 with wrap-around, and assert out_last on the output beat of count FRAME_LEN/LANES-1.
REQ-027 SHALL track the running minimum of exp_out across the frame; it restarts at the first beat of each frame.
REQ-028 SHALL pulse frame_exp_valid for exactly one cycle when the out_last beat transfers, with frame_exp holding that frame's minimum until the next strobe.
REQ-029 SHALL give a new beat arriving on the same cycle as the frame_exp_valid strobe a fresh running minimum, without corrupting the strobe value.

Reset
REQ-030 SHALL, on rst, clear out_valid, out_last, frame_exp_valid, dout_i, dout_q, exp_out, frame_exp and the beat counter to 0; in_ready then equals 1.
REQ-031 SHALL make rst asserted mid-frame discard the partial frame; the next accepted beat is beat 0.

Structure
REQ-032 SHALL place EXP_W computation, the ROUND_MODE enum and the saturate function in package fft_cbfp_pkg.
REQ-033 SHALL implement leading-sign count in sub-module fft_lsc (parameter WIDTH), instantiated 2xLANES times.

Verification
REQ-034 SHALL cover: all lanes 0 -> exp_out all 24, dout 0, out_valid one cycle after accept.
REQ-035 SHALL cover: din_i[3]=4096, other lanes 0 -> exp_out[0]=11, exp_out[1]=24, dout_i[3]=1024.
REQ-036 SHALL cover: ROUND_MODE=1, din_i[0]=8191, others 0 -> shift 11, dout_i[0]=2047 (saturated); ROUND_MODE=0 -> 2047 by truncation.
REQ-037 SHALL cover: out_ready low 3 cycles with in_valid high -> in_ready low, outputs stable, no beat lost or duplicated.
REQ-038 SHALL cover: 32 beats with din_i[0]=2^20 on beat 5 only -> out_last on beat 32, frame_exp=3, frame_exp_valid high for one cycle.
REQ-039 SHALL cover: rst asserted at beat 10 -> all outputs 0; next frame's out_last arrives after 32 further accepted beats.

Source files
------------

// File: rtl/fft_cbfp_pkg.sv
// fft_cbfp_pkg: shared exponent width, rounding-mode encoding and saturation helper
package fft_cbfp_pkg;

    typedef enum logic {
        RM_TRUNC = 1'b0,
        RM_ROUND = 1'b1
    } round_mode_e;

    function automatic int exp_width(input int width);
        return $clog2(width);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

endpackage

// File: rtl/fft_lsc.sv
// fft_lsc: leading-sign count, the number of bits below the MSB that repeat the MSB
module fft_lsc
    import fft_cbfp_pkg::*;
#(
    parameter int WIDTH = 25
) (
    input  logic [WIDTH-1:0]            x,
    output logic [exp_width(WIDTH)-1:0] s
);

    localparam int SW = exp_width(WIDTH);

    logic run;

    // walk down from MSB-1 while bits still match the sign bit
    always_comb begin
        s   = '0;
        run = 1'b1;
        for (int b = WIDTH - 2; b >= 0; b--) begin
            run = run && (x[b] == x[WIDTH-1]);
            s   = s + SW'(run);
        end
    end

endmodule

// File: rtl/fft_cbfp_stage.sv
// fft_cbfp_stage: convergent block floating point normalisation of one FFT beat
module fft_cbfp_stage
    import fft_cbfp_pkg::*;
#(
    parameter int WIDTH_IN   = 25,
    parameter int WIDTH_OUT  = 12,
    parameter int LANES      = 16,
    parameter int GROUP      = 8,
    parameter int FRAME_LEN  = 512,
    parameter int ROUND_MODE = 0
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic signed [LANES-1:0][WIDTH_IN-1:0]                 din_i,
    input  logic signed [LANES-1:0][WIDTH_IN-1:0]                 din_q,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic signed [LANES-1:0][WIDTH_OUT-1:0]                dout_i,
    output logic signed [LANES-1:0][WIDTH_OUT-1:0]                dout_q,
    output logic [LANES/GROUP-1:0][exp_width(WIDTH_IN)-1:0]       exp_out,
    output logic                                                  out_last,
    output logic [exp_width(WIDTH_IN)-1:0]                        frame_exp,
    output logic                                                  frame_exp_valid
);

    localparam int EXP_W = exp_width(WIDTH_IN);
    localparam int NG    = LANES / GROUP;
    localparam int SHR   = WIDTH_IN - WIDTH_OUT;
    localparam int BEATS = FRAME_LEN / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic signed [WIDTH_IN:0] HALF = $signed((WIDTH_IN + 1)'(1) << (SHR - 1));

    logic [LANES-1:0][EXP_W-1:0]     lsc_i;
    logic [LANES-1:0][EXP_W-1:0]     lsc_q;
    logic [NG-1:0][EXP_W-1:0]        shift;
    logic [EXP_W-1:0]                beat_min;
    logic [LANES-1:0][WIDTH_OUT-1:0] nxt_i;
    logic [LANES-1:0][WIDTH_OUT-1:0] nxt_q;
    logic [CNT_W-1:0]                cnt;
    logic [EXP_W-1:0]                run_min;
    logic                            accept;
    logic                            wrap;
    logic                            last_xfer;

    // shift never exceeds the group's headroom, so the left shift cannot overflow WIDTH_IN
    function automatic logic [WIDTH_OUT-1:0] scale(input logic signed [WIDTH_IN-1:0] x,
                                                   input logic [EXP_W-1:0] sh);
        logic signed [WIDTH_IN-1:0] up;
        logic signed [WIDTH_IN:0]   rnd;
        up  = x <<< sh;
        rnd = ($signed({up[WIDTH_IN-1], up}) + HALF) >>> SHR;
        return (ROUND_MODE == int'(RM_ROUND)) ? WIDTH_OUT'(saturate(64'(rnd), WIDTH_OUT))
                                              : WIDTH_OUT'(up >>> SHR);
    endfunction

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign wrap      = cnt == CNT_W'(BEATS - 1);
    assign last_xfer = out_valid && out_ready && out_last;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fft_lsc #(.WIDTH(WIDTH_IN)) u_lsc_i (.x(din_i[l]), .s(lsc_i[l]));
        fft_lsc #(.WIDTH(WIDTH_IN)) u_lsc_q (.x(din_q[l]), .s(lsc_q[l]));
        assign nxt_i[l] = scale($signed(din_i[l]), shift[l / GROUP]);
        assign nxt_q[l] = scale($signed(din_q[l]), shift[l / GROUP]);
    end

    // joint I/Q exponent per group, plus the smallest group exponent of the beat
    always_comb begin
        beat_min = EXP_W'(WIDTH_IN - 1);
        for (int g = 0; g < NG; g++) begin
            shift[g] = EXP_W'(WIDTH_IN - 1);
            for (int k = 0; k < GROUP; k++) begin
                shift[g] = (lsc_i[g*GROUP+k] < shift[g]) ? lsc_i[g*GROUP+k] : shift[g];
                shift[g] = (lsc_q[g*GROUP+k] < shift[g]) ? lsc_q[g*GROUP+k] : shift[g];
            end
            beat_min = (shift[g] < beat_min) ? shift[g] : beat_min;
        end
    end

    // output register, beat counter and running frame minimum; all hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            dout_i    <= '0;
            dout_q    <= '0;
            exp_out   <= '0;
            cnt       <= '0;
            run_min   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_last  <= wrap;
            dout_i    <= nxt_i;
            dout_q    <= nxt_q;
            exp_out   <= shift;
            cnt       <= wrap ? '0 : cnt + 1'b1;
            run_min   <= (cnt == '0 || beat_min < run_min) ? beat_min : run_min;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // frame exponent captured from run_min before a same-cycle first beat restarts it
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_exp_valid <= 1'b0;
            frame_exp       <= '0;
        end else begin
            frame_exp_valid <= last_xfer;
            if (last_xfer) frame_exp <= run_min;
        end
    end

endmodule

// File: tb/tb_fft_cbfp_stage.sv
// tb_fft_cbfp_stage: directed and random checks of both rounding modes against a reference model
module tb_fft_cbfp_stage;

    localparam int WI = 25, WO = 12, LANES = 16, GROUP = 8, FRAME_LEN = 512;
    localparam int NG = LANES / GROUP, EW = $clog2(WI), SHR = WI - WO, BEATS = FRAME_LEN / LANES;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [LANES-1:0][WI-1:0] din_i = '0, din_q = '0;
    logic in_ready, out_valid, out_last, frame_exp_valid;
    logic [LANES-1:0][WO-1:0] dout_i, dout_q;
    logic [NG-1:0][EW-1:0] exp_out;
    logic [EW-1:0] frame_exp;
    logic r_in_ready, r_out_valid, r_out_last, r_frame_exp_valid;
    logic [LANES-1:0][WO-1:0] r_dout_i, r_dout_q;
    logic [NG-1:0][EW-1:0] r_exp_out;
    logic [EW-1:0] r_frame_exp;
    int total = 0, bad = 0;

    typedef struct {
        logic [LANES*WO-1:0] di, dq, ri, rq;
        logic [NG*EW-1:0]    ex;
        bit                  last;
        int                  fmin;
    } exp_t;

    exp_t sb[$];
    int   mcnt = 0, fmin_run = 0, fe_hold = 0;
    bit   fev_due = 1'b0;

    always #5 clk = ~clk;

    fft_cbfp_stage #(.ROUND_MODE(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .din_i(din_i), .din_q(din_q), .out_valid(out_valid), .out_ready(out_ready),
        .dout_i(dout_i), .dout_q(dout_q), .exp_out(exp_out), .out_last(out_last),
        .frame_exp(frame_exp), .frame_exp_valid(frame_exp_valid)
    );

    fft_cbfp_stage #(.ROUND_MODE(1)) dut_rnd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready),
        .din_i(din_i), .din_q(din_q), .out_valid(r_out_valid), .out_ready(out_ready),
        .dout_i(r_dout_i), .dout_q(r_dout_q), .exp_out(r_exp_out), .out_last(r_out_last),
        .frame_exp(r_frame_exp), .frame_exp_valid(r_frame_exp_valid)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // headroom: largest s such that x fits in WI-s signed bits
    function automatic int lsc(input longint x);
        for (int s = WI - 1; s > 0; s--)
            if (x >= -(64'sd1 <<< (WI - 1 - s)) && x < (64'sd1 <<< (WI - 1 - s))) return s;
        return 0;
    endfunction

    function automatic longint scale(input longint x, input int sh, input bit rnd);
        longint y;
        y = x * (64'sd1 <<< sh);
        if (!rnd) return y >>> SHR;
        y = (y + (64'sd1 <<< (SHR - 1))) >>> SHR;
        if (y > (64'sd1 <<< (WO - 1)) - 1) return (64'sd1 <<< (WO - 1)) - 1;
        if (y < -(64'sd1 <<< (WO - 1))) return -(64'sd1 <<< (WO - 1));
        return y;
    endfunction

    function automatic exp_t model(output int bm);
        exp_t e;
        int sh[NG];
        int a, b;
        bm = WI - 1;
        for (int g = 0; g < NG; g++) begin
            sh[g] = WI - 1;
            for (int k = 0; k < GROUP; k++) begin
                a = lsc(longint'($signed(din_i[g*GROUP+k])));
                b = lsc(longint'($signed(din_q[g*GROUP+k])));
                if (a < sh[g]) sh[g] = a;
                if (b < sh[g]) sh[g] = b;
            end
            e.ex[g*EW +: EW] = EW'(sh[g]);
            if (sh[g] < bm) bm = sh[g];
        end
        for (int l = 0; l < LANES; l++) begin
            e.di[l*WO +: WO] = WO'(scale(longint'($signed(din_i[l])), sh[l/GROUP], 1'b0));
            e.dq[l*WO +: WO] = WO'(scale(longint'($signed(din_q[l])), sh[l/GROUP], 1'b0));
            e.ri[l*WO +: WO] = WO'(scale(longint'($signed(din_i[l])), sh[l/GROUP], 1'b1));
            e.rq[l*WO +: WO] = WO'(scale(longint'($signed(din_q[l])), sh[l/GROUP], 1'b1));
        end
        e.last = 1'b0;
        e.fmin = 0;
        return e;
    endfunction

    // scoreboard: beats enter on input transfer, leave on output transfer
    always @(negedge clk) begin
        exp_t e;
        int   bm;
        bit   due_n;
        if (rst) begin
            sb.delete();
            mcnt    = 0;
            fev_due = 1'b0;
            fe_hold = 0;
        end else begin
            chk("out_valid", out_valid, sb.size() != 0);
            chk("in_ready", in_ready, sb.size() == 0 || out_ready);
            if (fev_due || frame_exp_valid) chk("frame_exp_valid", frame_exp_valid, fev_due);
            chk("frame_exp", frame_exp, fe_hold);
            due_n = 1'b0;
            if (out_valid && sb.size() != 0) begin
                chk("dout_i", dout_i, sb[0].di);
                chk("dout_q", dout_q, sb[0].dq);
                chk("rnd_dout_i", r_dout_i, sb[0].ri);
                chk("rnd_dout_q", r_dout_q, sb[0].rq);
                chk("exp_out", exp_out, sb[0].ex);
                chk("out_last", out_last, sb[0].last);
                if (out_ready) begin
                    if (sb[0].last) begin
                        due_n   = 1'b1;
                        fe_hold = sb[0].fmin;
                    end
                    void'(sb.pop_front());
                end
            end
            fev_due = due_n;
            if (in_valid && in_ready) begin
                e = model(bm);
                if (mcnt == 0 || bm < fmin_run) fmin_run = bm;
                e.fmin = fmin_run;
                e.last = (mcnt == BEATS - 1);
                mcnt   = (mcnt + 1) % BEATS;
                sb.push_back(e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_din();
        din_i = '0;
        din_q = '0;
    endtask

    task automatic rand_din();
        logic signed [WI-1:0] t;
        int k;
        k = $urandom_range(0, WI - 1);
        for (int l = 0; l < LANES; l++) begin
            t = WI'($urandom);
            din_i[l] = t >>> k;
            t = WI'($urandom);
            din_q[l] = t >>> k;
        end
    endtask

    task automatic send();
        int n;
        n = 0;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            cyc();
            n++;
        end
        chk("send_ready", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_fev(input string tag, input int want);
        int n;
        n = 0;
        while (!frame_exp_valid && n < 10) begin
            cyc();
            n++;
        end
        chk({tag, "_strobe"}, frame_exp_valid, 1'b1);
        chk({tag, "_exp"}, frame_exp, want);
        cyc();
        chk({tag, "_pulse"}, frame_exp_valid, 1'b0);
        chk({tag, "_hold"}, frame_exp, want);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_fev", frame_exp_valid, 1'b0);
        chk("rst_dout_i", dout_i, '0);
        chk("rst_dout_q", dout_q, '0);
        chk("rst_exp_out", exp_out, '0);
        chk("rst_frame_exp", frame_exp, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        send();
        chk("zero_latency", out_valid, 1'b1);
        chk("zero_exp0", exp_out[0], 24);
        chk("zero_exp1", exp_out[1], 24);
        chk("zero_dout", dout_i, '0);
        din_i[3] = 25'd4096;
        send();
        chk("lane3_exp0", exp_out[0], 11);
        chk("lane3_exp1", exp_out[1], 24);
        chk("lane3_dout", dout_i[3], 1024);
        clear_din();
        din_i[0] = 25'd8191;
        send();
        chk("sat_exp0", exp_out[0], 11);
        chk("trunc_dout", dout_i[0], 2047);
        chk("round_sat_dout", r_dout_i[0], 2047);
        rand_din();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (3) begin
            cyc();
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        send();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        clear_din();
        in_valid = 1'b1;
        for (int b = 1; b <= BEATS; b++) begin
            din_i[0] = (b == 5) ? 25'd1048576 : 25'd0;
            cyc();
            chk("frame_last", out_last, b == BEATS);
        end
        in_valid = 1'b0;
        wait_fev("frame", 3);
        in_valid = 1'b1;
        repeat (10) begin
            rand_din();
            cyc();
        end
        rst = 1'b1;
        cyc();
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_last", out_last, 1'b0);
        chk("midrst_fev", frame_exp_valid, 1'b0);
        chk("midrst_dout_i", dout_i, '0);
        chk("midrst_dout_q", dout_q, '0);
        chk("midrst_exp_out", exp_out, '0);
        chk("midrst_frame_exp", frame_exp, '0);
        chk("midrst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        clear_din();
        for (int b = 1; b <= BEATS; b++) begin
            cyc();
            chk("after_rst_last", out_last, b == BEATS);
        end
        in_valid = 1'b0;
        wait_fev("after_rst", 24);
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = (c == 700);
            rand_din();
            cyc();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
